// File: rtl/lsu_mem_initiator_if.sv
// Core-side request/response and memory-side bus for lsu_mem_initiator.
// The slave modport is the initiator's view. The master modport is the
// environment's view: it drives requests and answers memory reads.
interface lsu_mem_initiator_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
           MemRead, MemWrite, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           MemRead, MemWrite, mem_addr, mem_wdata
  );
endinterface

// File: rtl/lsu_mem_initiator.sv
// Load/store initiator between the core execute stage and a word-wide data
// memory. Byte and halfword stores use read-modify-write. Loads are sign- or
// zero-extended. Misaligned or illegal requests return an error and make no
// memory access.
// Optional feature: define LSU_BOUNDS_CHECK_EN to flag addresses above the
// memory as errors. Without it the word index wraps modulo DEPTH.
module lsu_mem_initiator #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input logic                clk,
  input logic                reset,
  lsu_mem_initiator_if.slave bus
);

  typedef enum logic [2:0] {IDLE, LD, ST, RMW_RD, RMW_WR, RESP} state_t;

  state_t      state_q;
  logic [1:0]  lane_q;
  logic [2:0]  funct3_q;
  logic [15:0] wdata_q;
  logic        ready_q;
  logic        respValid_q;
  logic        respErr_q;
  logic [31:0] respRdata_q;
  logic        memRead_q;
  logic        memWrite_q;
  logic [31:0] memAddr_q;
  logic [31:0] memWdata_q;

  logic        illegal;
  logic        misaligned;
  logic        outOfRange;
  logic        reqErr;

  // Select the addressed byte/half of a memory word and extend it to 32 bits.
  function automatic logic [31:0] extendLoad(input logic [31:0] word,
                                             input logic [1:0]  lane,
                                             input logic [2:0]  f3);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b100:  return {24'h0, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b101:  return {16'h0, h};
      default: return word;
    endcase
  endfunction

  // Replace one byte or half of the old word with the store data.
  function automatic logic [31:0] mergeStore(input logic [31:0] old,
                                             input logic [15:0] wd,
                                             input logic [1:0]  lane,
                                             input logic        isHalf);
    logic [31:0] r;
    r = old;
    if (!isHalf)
      r[{lane, 3'b000} +: 8] = wd[7:0];
    else if (lane[1])
      r[31:16] = wd;
    else
      r[15:0] = wd;
    return r;
  endfunction

  // Classify the incoming request: unsupported funct3 encodings and
  // unsigned stores are illegal; H needs even, W needs word alignment.
  always_comb begin
    illegal    = 1'b0;
    misaligned = 1'b0;
    case (bus.req_funct3)
      3'b000: ;
      3'b001: misaligned = bus.req_addr[0];
      3'b010: misaligned = |bus.req_addr[1:0];
      3'b100: illegal = bus.req_we;
      3'b101: begin
        illegal    = bus.req_we;
        misaligned = bus.req_addr[0];
      end
      default: illegal = 1'b1;
    endcase
  end

`ifdef LSU_BOUNDS_CHECK_EN
  assign outOfRange = |bus.req_addr[31:AW+2];
`else
  assign outOfRange = 1'b0;
`endif

  assign reqErr = illegal | misaligned | outOfRange;

  // Main sequencer: every bus output is a register updated with the state,
  // so reset clears MemRead/MemWrite immediately and drops the request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      lane_q      <= 2'b00;
      funct3_q    <= 3'b000;
      wdata_q     <= 16'h0;
      ready_q     <= 1'b1;
      respValid_q <= 1'b0;
      respErr_q   <= 1'b0;
      respRdata_q <= 32'h0;
      memRead_q   <= 1'b0;
      memWrite_q  <= 1'b0;
      memAddr_q   <= 32'h0;
      memWdata_q  <= 32'h0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            lane_q    <= bus.req_addr[1:0];
            funct3_q  <= bus.req_funct3;
            wdata_q   <= bus.req_wdata[15:0];
            memAddr_q <= {{(32-AW){1'b0}}, bus.req_addr[AW+1:2]};
            ready_q   <= 1'b0;
            if (reqErr) begin
              state_q     <= RESP;
              respValid_q <= 1'b1;
              respErr_q   <= 1'b1;
              respRdata_q <= 32'h0;
            end else if (!bus.req_we) begin
              state_q   <= LD;
              memRead_q <= 1'b1;
            end else if (bus.req_funct3 == 3'b010) begin
              state_q    <= ST;
              memWrite_q <= 1'b1;
              memWdata_q <= bus.req_wdata;
            end else begin
              state_q   <= RMW_RD;
              memRead_q <= 1'b1;
            end
          end
        end
        LD: begin
          memRead_q   <= 1'b0;
          respRdata_q <= extendLoad(bus.mem_rdata, lane_q, funct3_q);
          respValid_q <= 1'b1;
          respErr_q   <= 1'b0;
          state_q     <= RESP;
        end
        ST: begin
          memWrite_q  <= 1'b0;
          respRdata_q <= 32'h0;
          respValid_q <= 1'b1;
          respErr_q   <= 1'b0;
          state_q     <= RESP;
        end
        RMW_RD: begin
          memRead_q  <= 1'b0;
          memWrite_q <= 1'b1;
          memWdata_q <= mergeStore(bus.mem_rdata, wdata_q, lane_q, funct3_q[0]);
          state_q    <= RMW_WR;
        end
        RMW_WR: begin
          memWrite_q  <= 1'b0;
          respRdata_q <= 32'h0;
          respValid_q <= 1'b1;
          respErr_q   <= 1'b0;
          state_q     <= RESP;
        end
        RESP: begin
          respValid_q <= 1'b0;
          respErr_q   <= 1'b0;
          ready_q     <= 1'b1;
          state_q     <= IDLE;
        end
        default: begin
          memRead_q   <= 1'b0;
          memWrite_q  <= 1'b0;
          respValid_q <= 1'b0;
          ready_q     <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready  = ready_q;
  assign bus.resp_valid = respValid_q;
  assign bus.resp_err   = respErr_q;
  assign bus.resp_rdata = respRdata_q;
  assign bus.MemRead    = memRead_q;
  assign bus.MemWrite   = memWrite_q;
  assign bus.mem_addr   = memAddr_q;
  assign bus.mem_wdata  = memWdata_q;

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Bench for lsu_mem_initiator: a byte-array memory model predicts every
// request's timing, memory traffic and response, and a per-cycle compare
// process checks the DUT against it. Directed literals pin the model.
module tb_lsu_mem_initiator;
  localparam int DEPTH = 64;

  typedef struct {
    int          lat;
    int          rdCyc;
    int          wrCyc;
    logic        err;
    logic        wr;
    logic [31:0] rdata;
    logic [31:0] idx;
    logic [31:0] wword;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  lsu_mem_initiator_if bus();

  lsu_mem_initiator #(.DEPTH(DEPTH), .AW(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [31:0] preMem  [DEPTH];
  logic [31:0] envMem  [DEPTH];
  logic        written [DEPTH];
  logic [31:0] refMem  [DEPTH];

  int checks = 0;
  int errors = 0;
  int wrCount = 0;
  int rdCount = 0;
  int respCount = 0;
  logic [31:0] lastWdata = 32'h0;
  logic [31:0] lastWaddr = 32'h0;

  exp_t expQ[$];

  assign bus.mem_rdata = written[bus.mem_addr[5:0]] ? envMem[bus.mem_addr[5:0]]
                                                    : preMem[bus.mem_addr[5:0]];

  // Environment memory: writes land on the rising edge.
  always @(posedge clk) begin
    if (bus.MemWrite) begin
      envMem[bus.mem_addr[5:0]]  = bus.mem_wdata;
      written[bus.mem_addr[5:0]] = 1'b1;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic reportTimeout(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: timed out at %0t", name, $time);
  endtask

  // Reference model: treat memory as bytes, apply the RISC-V rules directly.
  function automatic exp_t modelOp(input logic we, input logic [2:0] f3,
                                   input logic [31:0] addr, input logic [31:0] wdata);
    exp_t        e;
    int          size;
    int          lane;
    logic [7:0]  b [4];
    logic [31:0] word;
    logic [15:0] h;
    logic        bad;
    e = '{default: 0};
    lane  = int'(addr[1:0]);
    e.idx = {26'h0, addr[7:2]};
    case (f3)
      3'd0, 3'd4: size = 1;
      3'd1, 3'd5: size = 2;
      default:    size = 4;
    endcase
    bad = (f3 == 3'd3) || (f3 >= 3'd6) || (we && f3 >= 3'd4) || ((addr % size) != 0);
`ifdef LSU_BOUNDS_CHECK_EN
    bad = bad || (addr >= 32'd256);
`endif
    if (bad) begin
      e.lat = 1;
      e.err = 1'b1;
      return e;
    end
    word = refMem[addr[7:2]];
    for (int k = 0; k < 4; k++) b[k] = word[8*k +: 8];
    if (!we) begin
      e.lat = 2;
      e.rdCyc = 1;
      if (size == 1) begin
        if (f3 == 3'd0 && b[lane][7]) e.rdata = {24'hFFFFFF, b[lane]};
        else                          e.rdata = {24'h0, b[lane]};
      end else if (size == 2) begin
        h = {b[lane+1], b[lane]};
        if (f3 == 3'd1 && h[15]) e.rdata = {16'hFFFF, h};
        else                     e.rdata = {16'h0, h};
      end else begin
        e.rdata = word;
      end
    end else begin
      e.wr = 1'b1;
      if (size == 4) begin
        e.lat = 2;
        e.wrCyc = 1;
        e.wword = wdata;
      end else begin
        e.lat = 3;
        e.rdCyc = 1;
        e.wrCyc = 2;
        for (int k = 0; k < size; k++) b[lane+k] = wdata[8*k +: 8];
        e.wword = {b[3], b[2], b[1], b[0]};
      end
    end
    return e;
  endfunction

  // Per-cycle compare: track the in-flight request and check every output.
  logic busy = 1'b0;
  logic acceptNext = 1'b0;
  int   cyc = 0;
  exp_t cur;
  logic [31:0] hold = 32'h0;

  always @(negedge clk) begin
    if (bus.MemWrite) begin
      wrCount++;
      lastWdata = bus.mem_wdata;
      lastWaddr = bus.mem_addr;
    end
    if (bus.MemRead) rdCount++;
    if (bus.resp_valid) respCount++;
    if (!reset) begin
      busy = 1'b0;
      acceptNext = 1'b0;
      hold = 32'h0;
      expQ.delete();
      checkOutput("rst_req_ready", {31'h0, bus.req_ready}, 32'd1);
      checkOutput("rst_resp_valid", {31'h0, bus.resp_valid}, 32'd0);
      checkOutput("rst_resp_err", {31'h0, bus.resp_err}, 32'd0);
      checkOutput("rst_resp_rdata", bus.resp_rdata, 32'h0);
      checkOutput("rst_MemRead", {31'h0, bus.MemRead}, 32'd0);
      checkOutput("rst_MemWrite", {31'h0, bus.MemWrite}, 32'd0);
      checkOutput("rst_mem_addr", bus.mem_addr, 32'h0);
      checkOutput("rst_mem_wdata", bus.mem_wdata, 32'h0);
    end else begin
      if (busy) begin
        if (cyc == cur.lat) busy = 1'b0;
        else cyc++;
      end
      if (acceptNext) begin
        if (expQ.size() == 0) begin
          reportTimeout("expectation_queue_empty");
        end else begin
          cur  = expQ.pop_front();
          busy = 1'b1;
          cyc  = 1;
        end
      end
      if (busy) begin
        if (cyc == cur.lat) hold = cur.rdata;
        checkOutput("req_ready_busy", {31'h0, bus.req_ready}, 32'd0);
        checkOutput("resp_valid", {31'h0, bus.resp_valid}, {31'h0, cyc == cur.lat});
        checkOutput("MemRead", {31'h0, bus.MemRead}, {31'h0, cyc == cur.rdCyc});
        checkOutput("MemWrite", {31'h0, bus.MemWrite}, {31'h0, cyc == cur.wrCyc});
        if (cyc == cur.rdCyc || cyc == cur.wrCyc) checkOutput("mem_addr", bus.mem_addr, cur.idx);
        if (cyc == cur.wrCyc) checkOutput("mem_wdata", bus.mem_wdata, cur.wword);
        if (cyc == cur.lat) checkOutput("resp_err", {31'h0, bus.resp_err}, {31'h0, cur.err});
      end else begin
        checkOutput("req_ready_idle", {31'h0, bus.req_ready}, 32'd1);
        checkOutput("resp_valid_idle", {31'h0, bus.resp_valid}, 32'd0);
        checkOutput("MemRead_idle", {31'h0, bus.MemRead}, 32'd0);
        checkOutput("MemWrite_idle", {31'h0, bus.MemWrite}, 32'd0);
      end
      checkOutput("resp_rdata", bus.resp_rdata, hold);
      acceptNext = bus.req_valid && bus.req_ready;
    end
  end

  // Issue one request, update the model, and wait for its response.
  task automatic applyStimulus(input logic we, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               output logic [31:0] rdata, output logic err);
    exp_t e;
    logic ok;
    e = modelOp(we, f3, addr, wdata);
    @(posedge clk); #1;
    expQ.push_back(e);
    if (e.wr && !e.err) refMem[e.idx[5:0]] = e.wword;
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.req_ready) begin ok = 1'b1; break; end
    end
    if (!ok) reportTimeout("req_ready_wait");
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    rdata = 32'hX;
    err   = 1'bX;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.resp_valid) begin
        ok = 1'b1;
        rdata = bus.resp_rdata;
        err   = bus.resp_err;
        break;
      end
    end
    if (!ok) reportTimeout("resp_valid_wait");
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  logic [2:0] f3Tab [10] = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};

  // Directed literal scenarios followed by randomized traffic.
  initial begin
    logic [31:0] rd;
    logic        er;
    int          w0, r0, v0;
    exp_t        e;
    logic [31:0] addr;
    logic [2:0]  f3;
    logic        we;

    bus.req_valid = 1'b0;
    bus.req_we = 1'b0;
    bus.req_funct3 = 3'b0;
    bus.req_addr = 32'h0;
    bus.req_wdata = 32'h0;
    for (int i = 0; i < DEPTH; i++) begin
      preMem[i]  = $urandom;
      envMem[i]  = 32'h0;
      written[i] = 1'b0;
    end
    preMem[0] = 32'h01234567;
    preMem[3] = 32'h8899AABB;
    for (int i = 0; i < DEPTH; i++) refMem[i] = preMem[i];

    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    reset = 1'b1;

    applyStimulus(1'b0, 3'b000, 32'h0D, 32'h0, rd, er);
    checkOutput("lit_LB_0D", rd, 32'hFFFFFFAA);
    applyStimulus(1'b0, 3'b100, 32'h0D, 32'h0, rd, er);
    checkOutput("lit_LBU_0D", rd, 32'h000000AA);
    applyStimulus(1'b0, 3'b001, 32'h0E, 32'h0, rd, er);
    checkOutput("lit_LH_0E", rd, 32'hFFFF8899);
    applyStimulus(1'b0, 3'b101, 32'h0E, 32'h0, rd, er);
    checkOutput("lit_LHU_0E", rd, 32'h00008899);

    w0 = wrCount; r0 = rdCount;
    applyStimulus(1'b1, 3'b000, 32'h0E, 32'h123, rd, er);
    checkOutput("lit_SB_wdata", lastWdata, 32'h8823AABB);
    checkOutput("lit_SB_writes", 32'(wrCount - w0), 32'd1);
    checkOutput("lit_SB_reads", 32'(rdCount - r0), 32'd1);
    applyStimulus(1'b0, 3'b010, 32'h0C, 32'h0, rd, er);
    checkOutput("lit_LW_after_SB", rd, 32'h8823AABB);

    w0 = wrCount;
    applyStimulus(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, rd, er);
    checkOutput("lit_SW_writes", 32'(wrCount - w0), 32'd1);
    checkOutput("lit_SW_addr", lastWaddr, 32'd4);
    checkOutput("lit_SW_err", {31'h0, er}, 32'd0);

    w0 = wrCount; r0 = rdCount;
    applyStimulus(1'b0, 3'b010, 32'h0E, 32'h0, rd, er);
    checkOutput("lit_LW_misaligned_err", {31'h0, er}, 32'd1);
    applyStimulus(1'b1, 3'b001, 32'h0F, 32'h55AA, rd, er);
    checkOutput("lit_SH_misaligned_err", {31'h0, er}, 32'd1);
    applyStimulus(1'b0, 3'b011, 32'h0C, 32'h0, rd, er);
    checkOutput("lit_funct3_011_err", {31'h0, er}, 32'd1);
    checkOutput("lit_err_rdata", rd, 32'h0);
    checkOutput("lit_err_no_access", 32'((wrCount - w0) + (rdCount - r0)), 32'd0);

    // Reset while the SB 0x0C read phase is in progress.
    e = modelOp(1'b1, 3'b000, 32'h0C, 32'h55);
    @(posedge clk); #1;
    expQ.push_back(e);
    bus.req_valid = 1'b1;
    bus.req_we = 1'b1;
    bus.req_funct3 = 3'b000;
    bus.req_addr = 32'h0C;
    bus.req_wdata = 32'h55;
    @(negedge clk);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(negedge clk); #1;
    checkOutput("lit_rmw_rd_MemRead", {31'h0, bus.MemRead}, 32'd1);
    w0 = wrCount; v0 = respCount;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    reset = 1'b1;
    checkOutput("lit_abort_ready", {31'h0, bus.req_ready}, 32'd1);
    repeat (3) @(negedge clk);
    checkOutput("lit_abort_no_write", 32'(wrCount - w0), 32'd0);
    checkOutput("lit_abort_no_resp", 32'(respCount - v0), 32'd0);
    applyStimulus(1'b0, 3'b010, 32'h0C, 32'h0, rd, er);
    checkOutput("lit_abort_word3", rd, 32'h8823AABB);

    applyStimulus(1'b0, 3'b010, 32'h100, 32'h0, rd, er);
`ifdef LSU_BOUNDS_CHECK_EN
    checkOutput("lit_LW_100_err", {31'h0, er}, 32'd1);
`else
    checkOutput("lit_LW_100_wrap", rd, 32'h01234567);
    checkOutput("lit_LW_100_ok", {31'h0, er}, 32'd0);
`endif

    for (int n = 0; n < 200; n++) begin
      f3   = f3Tab[$urandom_range(0, 9)];
      we   = 1'($urandom_range(0, 1));
      addr = $urandom_range(0, 255);
      if ($urandom_range(0, 7) == 0) addr = addr | ($urandom & 32'hFFFFFF00);
      if ($urandom_range(0, 3) != 0) begin
        if (f3[1:0] == 2'b10) addr[1:0] = 2'b00;
        if (f3[1:0] == 2'b01) addr[0] = 1'b0;
      end
      repeat ($urandom_range(0, 2)) @(posedge clk);
      applyStimulus(we, f3, addr, $urandom, rd, er);
    end

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
